seq_runner: RTL



---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_core.sv | 39 +++
 rtl/seq_runner.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and the update rule for the 3-bit nonlinear feedback register.
package seq_pkg;

    localparam int SEQ_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // One register advance on {a,b,c}: x = a^b^c, a' = x, b' = x|c, c' = b.
    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
        logic x;
        x = s[2] ^ s[1] ^ s[0];
        return {x, x | s[0], s[1]};
    endfunction

endpackage

// File: rtl/seq_core.sv
// The {a,b,c} register itself: load a seed or advance by one step.
module seq_core
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [SEQ_W-1:0] seed_i,
    output logic [SEQ_W-1:0] state_o
);

    logic [SEQ_W-1:0] state_q;
    logic [SEQ_W-1:0] state_d;

    // Next register value; a load takes priority over an advance.
    always_comb begin
        // NOTE: assigning the hold value first means every path writes state_d, so no latch is inferred.
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (adv_i) begin
            state_d = seq_next(state_q);
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of block order.
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/seq_runner.sv
// Run controller: loads a seed, advances the register for a latched step
// count with stall support, records the first return to the seed, and
// pulses done for one cycle at the end of each run.
module seq_runner
    import seq_pkg::*;
#(
    parameter int MAX_STEPS = 15,
    parameter int CW        = $clog2(MAX_STEPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEQ_W-1:0] seed,
    input  logic [CW-1:0]    steps,
    input  logic             hold,
    output logic [SEQ_W-1:0] state_q,
    output logic [CW-1:0]    step_cnt,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    period,
    output logic             period_valid
);

    seq_state_t       fsm_q, fsm_d;
    logic [SEQ_W-1:0] seed_q, seed_d;
    logic [CW-1:0]    steps_q, steps_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic             load;
    logic             adv;
    logic [CW-1:0]    steps_clamped;

    seq_core u_core (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .adv_i   (adv),
        .seed_i  (seed),
        .state_o (state_q)
    );

    assign steps_clamped = (steps > CW'(MAX_STEPS)) ? CW'(MAX_STEPS) : steps;

    // FSM next state, run bookkeeping and register controls.
    always_comb begin
        fsm_d    = fsm_q;
        seed_d   = seed_q;
        steps_d  = steps_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pvalid_d = pvalid_q;
        load     = 1'b0;
        adv      = 1'b0;
        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    fsm_d    = RUN;
                    load     = 1'b1;
                    seed_d   = seed;
                    steps_d  = steps_clamped;
                    cnt_d    = '0;
                    period_d = '0;
                    pvalid_d = 1'b0;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (cnt_q == steps_q) begin
                        fsm_d = DONE;
                    end else begin
                        adv   = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        // Only the first return to the seed counts as the period.
                        if (!pvalid_q && (seq_next(state_q) == seed_q)) begin
                            period_d = cnt_q + 1'b1;
                            pvalid_d = 1'b1;
                        end
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // FSM state and run bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q    <= IDLE;
            seed_q   <= '0;
            steps_q  <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            seed_q   <= seed_d;
            steps_q  <= steps_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign busy         = (fsm_q == RUN);
    assign done         = (fsm_q == DONE);
    assign step_cnt     = cnt_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;

endmodule
